hci_queue_port: RTL
===================

Name: hci_queue_port

Overview:
- Sits directly downstream of the AHB-Lite-to-CSR bridge, on the I3C SW CSR access interface (req / is_wr / addr / wr_data / stall / ack / err).
- Decodes two queue-port register addresses:
  - CMD_PORT: write-only; pushes into an internal command FIFO.
  - RESP_PORT: read-only; pops from an internal response FIFO.
- Applies back-pressure through the stall signals and flags protocol errors.
- Feeds the command FIFO to the controller core over valid/ready, and collects responses from the core over valid/ready.

Parameters:
- ADDR_WIDTH, 12, width of s_cpuif_addr.
- DATA_WIDTH, 32, CSR data and queue entry width.
- CMD_PORT_ADDR, 12'h0C0, byte address of the command port.
- RESP_PORT_ADDR, 12'h0C4, byte address of the response port.
- CMD_DEPTH, 8, command FIFO entries; power of two, ≥2.
- RESP_DEPTH, 8, response FIFO entries; power of two, ≥2.
- RD_TIMEOUT, 255, max consecutive stalled read cycles before an error response; ≥1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- s_cpuif_req  in  1  request strobe.
- s_cpuif_req_is_wr  in  1  1 = write.
- s_cpuif_addr  in  ADDR_WIDTH  byte address.
- s_cpuif_wr_data  in  DATA_WIDTH  write data.
- s_cpuif_wr_biten  in  DATA_WIDTH  bit enables; pushes require all ones.
- s_cpuif_req_stall_wr  out  1  write stall.
- s_cpuif_req_stall_rd  out  1  read stall.
- s_cpuif_rd_ack  out  1  read complete.
- s_cpuif_rd_err  out  1  read error.
- s_cpuif_rd_data  out  DATA_WIDTH  read data.
- s_cpuif_wr_ack  out  1  write complete.
- s_cpuif_wr_err  out  1  write error.
- cmd_valid_o  out  1  command FIFO head valid.
- cmd_data_o  out  DATA_WIDTH  command FIFO head.
- cmd_ready_i  in  1  core pops command.
- resp_valid_i  in  1  core offers response.
- resp_data_i  in  DATA_WIDTH  response word.
- resp_ready_o  out  1  response FIFO not full.
- cmd_count_o  out  $clog2(CMD_DEPTH+1)  command occupancy.
- resp_count_o  out  $clog2(RESP_DEPTH+1)  response occupancy.

Behaviour:
- **Reset:** all outputs 0. FIFOs emptied, timeout counter cleared, pending ack dropped. A request in flight during reset gets no ack.
- **Request rules:**
  - A request is a cycle with s_cpuif_req=1.
  - If a stall is asserted in that cycle, upstream repeats the identical request next cycle. The block holds no request state except the timeout counter.
- **Stalls:** combinational from req, is_wr, addr and *registered* occupancy.
  - stall_wr = req & wr & addr==CMD_PORT_ADDR & cmd full.
  - stall_rd = req & !wr & addr==RESP_PORT_ADDR & resp empty & timeout counter < RD_TIMEOUT.
- **Acceptance:** a request is accepted when the relevant stall is low. The result is registered and ack/err/data are driven for exactly one cycle; latency is 1 cycle after the accepting cycle.
- **Write to CMD_PORT_ADDR, accepted:**
  - biten all ones: push wr_data; wr_ack=1, wr_err=0.
  - Otherwise: no push; wr_ack=1, wr_err=1.
- **Read from RESP_PORT_ADDR, accepted:**
  - Not empty: pop; rd_ack=1, rd_data=head, rd_err=0.
  - Empty (timeout reached): rd_ack=1, rd_err=1, rd_data=0.
- **Timeout counter:**
  - Increments on each stalled read cycle, saturating at RD_TIMEOUT.
  - Clears on any accepted request or any cycle without a stalled read.
- **Wrong direction or unmapped address:** read from CMD_PORT, write to RESP_PORT, or any other address → ack with err=1 next cycle, rd_data=0, no FIFO change.
- **FIFOs:**
  - Circular buffers with wrap-around pointers.
  - Occupancy counters updated as +push −pop.
  - Simultaneous push and pop leaves count unchanged, including at full (cmd) and empty (resp).
- **Push/pop and port interaction:**
  - Command pop: cmd_valid_o & cmd_ready_i.
  - Response push: resp_valid_i & resp_ready_o.
  - A stall decision uses the pre-update count. A same-cycle core pop does not un-stall a full write, and a same-cycle resp push does not un-stall an empty read.
- **Ack overlap:** at most one ack per cycle. A new request in the ack cycle is legal and is processed normally.

Optional Feature:
- Macro: HCI_QUEUE_PORT_THLD_EN.
- With the macro defined, add port resp_thld_i (in, $clog2(RESP_DEPTH+1)) and port resp_thld_o (out, 1).
  - resp_thld_o is registered: 1 when resp_count ≥ resp_thld_i and resp_thld_i ≠ 0.
  - resp_thld_o is 0 on reset.
- Without the macro, both ports are absent and there is no threshold logic.

Test Plan:
- Three writes 0xA1, 0xA2, 0xA3 to 0x0C0, cmd_ready_i=1 → three wr_ack without err; cmd_data_o presents 0xA1, 0xA2, 0xA3 in order; cmd_count_o returns to 0.
- Fill the command FIFO with 8 writes (cmd_ready_i=0), then a 9th write → stall_wr=1 while held. Raise cmd_ready_i for 1 cycle → stall drops the cycle after; wr_ack follows 1 cycle later; count stays 8.
- Core pushes 0x55 then 0x66, then two reads of 0x0C4 → rd_data 0x55, then 0x66, each ack 1 cycle after the request; resp_count_o ends at 0.
- Read 0x0C4 while empty with RD_TIMEOUT=4 → stall_rd high 4 cycles, then rd_ack=1, rd_err=1, rd_data=0.
- Read 0x0C0, write 0x0C4, write 0x100, write with biten=0x0000FFFF → each acks with err=1; FIFO counts unchanged.
- Reset asserted during a stalled write with a full FIFO → next cycle all outputs 0, counts 0, no ack issued.

Source files
------------

// File: rtl/hci_queue_port.sv
// ============================================================================
// Module   : hci_queue_port
// Brief    : CSR-side command/response queue ports for the I3C HCI. Optional
//            response-threshold flag enabled with HCI_QUEUE_PORT_THLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hci_queue_port #(
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] CMD_PORT_ADDR  = 12'h0C0,
    parameter logic [ADDR_WIDTH-1:0] RESP_PORT_ADDR = 12'h0C4,
    parameter int                    CMD_DEPTH      = 8,
    parameter int                    RESP_DEPTH     = 8,
    parameter int                    RD_TIMEOUT     = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              s_cpuif_req,
    input  logic                              s_cpuif_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]             s_cpuif_addr,
    input  logic [DATA_WIDTH-1:0]             s_cpuif_wr_data,
    input  logic [DATA_WIDTH-1:0]             s_cpuif_wr_biten,
    output logic                              s_cpuif_req_stall_wr,
    output logic                              s_cpuif_req_stall_rd,
    output logic                              s_cpuif_rd_ack,
    output logic                              s_cpuif_rd_err,
    output logic [DATA_WIDTH-1:0]             s_cpuif_rd_data,
    output logic                              s_cpuif_wr_ack,
    output logic                              s_cpuif_wr_err,
    output logic                              cmd_valid_o,
    output logic [DATA_WIDTH-1:0]             cmd_data_o,
    input  logic                              cmd_ready_i,
    input  logic                              resp_valid_i,
    input  logic [DATA_WIDTH-1:0]             resp_data_i,
    output logic                              resp_ready_o,
`ifdef HCI_QUEUE_PORT_THLD_EN
    input  logic [$clog2(RESP_DEPTH+1)-1:0]   resp_thld_i,
    output logic                              resp_thld_o,
`endif
    output logic [$clog2(CMD_DEPTH+1)-1:0]    cmd_count_o,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   resp_count_o
);

    localparam int c_CMD_AW = $clog2(CMD_DEPTH);
    localparam int c_CMD_CW = $clog2(CMD_DEPTH + 1);
    localparam int c_RSP_AW = $clog2(RESP_DEPTH);
    localparam int c_RSP_CW = $clog2(RESP_DEPTH + 1);
    localparam int c_TO_W   = $clog2(RD_TIMEOUT + 1);

    localparam logic [c_CMD_CW-1:0] c_CMD_FULL = c_CMD_CW'(CMD_DEPTH);
    localparam logic [c_RSP_CW-1:0] c_RSP_FULL = c_RSP_CW'(RESP_DEPTH);
    localparam logic [c_TO_W-1:0]   c_TO_MAX   = c_TO_W'(RD_TIMEOUT);

    logic [DATA_WIDTH-1:0] r_cmd_mem [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] r_rsp_mem [RESP_DEPTH];

    logic [c_CMD_AW-1:0]   r_cmd_wptr_q, w_cmd_wptr_d, r_cmd_rptr_q, w_cmd_rptr_d;
    logic [c_CMD_CW-1:0]   r_cmd_cnt_q,  w_cmd_cnt_d;
    logic [c_RSP_AW-1:0]   r_rsp_wptr_q, w_rsp_wptr_d, r_rsp_rptr_q, w_rsp_rptr_d;
    logic [c_RSP_CW-1:0]   r_rsp_cnt_q,  w_rsp_cnt_d;
    logic [c_TO_W-1:0]     r_to_cnt_q,   w_to_cnt_d;
    logic                  r_wr_ack_q, w_wr_ack_d, r_wr_err_q, w_wr_err_d;
    logic                  r_rd_ack_q, w_rd_ack_d, r_rd_err_q, w_rd_err_d;
    logic [DATA_WIDTH-1:0] r_rd_data_q, w_rd_data_d;

    logic w_hit_cmd, w_hit_rsp, w_biten_full;
    logic w_cmd_full, w_rsp_empty, w_to_reached;
    logic w_stall_wr, w_stall_rd, w_accept;
    logic w_cmd_push, w_cmd_pop, w_rsp_push, w_rsp_pop;

    // Decode and stall decisions use only registered occupancy, so a
    // same-cycle core push/pop never changes this cycle's stall.
    always_comb begin
        w_hit_cmd    = (s_cpuif_addr == CMD_PORT_ADDR);
        w_hit_rsp    = (s_cpuif_addr == RESP_PORT_ADDR);
        w_biten_full = &s_cpuif_wr_biten;
        w_cmd_full   = (r_cmd_cnt_q == c_CMD_FULL);
        w_rsp_empty  = (r_rsp_cnt_q == '0);
        w_to_reached = (r_to_cnt_q >= c_TO_MAX);
        w_stall_wr   = !rst_i && s_cpuif_req && s_cpuif_req_is_wr && w_hit_cmd && w_cmd_full;
        w_stall_rd   = !rst_i && s_cpuif_req && !s_cpuif_req_is_wr && w_hit_rsp
                       && w_rsp_empty && !w_to_reached;
        w_accept     = s_cpuif_req && !w_stall_wr && !w_stall_rd;
        w_cmd_push   = w_accept && s_cpuif_req_is_wr && w_hit_cmd && w_biten_full;
        w_cmd_pop    = cmd_valid_o && cmd_ready_i;
        w_rsp_push   = resp_valid_i && resp_ready_o;
        w_rsp_pop    = w_accept && !s_cpuif_req_is_wr && w_hit_rsp && !w_rsp_empty;
    end

    always_comb begin
        w_cmd_wptr_d = w_cmd_push ? r_cmd_wptr_q + c_CMD_AW'(1) : r_cmd_wptr_q;
        w_cmd_rptr_d = w_cmd_pop  ? r_cmd_rptr_q + c_CMD_AW'(1) : r_cmd_rptr_q;
        w_rsp_wptr_d = w_rsp_push ? r_rsp_wptr_q + c_RSP_AW'(1) : r_rsp_wptr_q;
        w_rsp_rptr_d = w_rsp_pop  ? r_rsp_rptr_q + c_RSP_AW'(1) : r_rsp_rptr_q;

        w_cmd_cnt_d = r_cmd_cnt_q;
        case ({w_cmd_push, w_cmd_pop})
            2'b10:   w_cmd_cnt_d = r_cmd_cnt_q + c_CMD_CW'(1);
            2'b01:   w_cmd_cnt_d = r_cmd_cnt_q - c_CMD_CW'(1);
            default: w_cmd_cnt_d = r_cmd_cnt_q;
        endcase

        w_rsp_cnt_d = r_rsp_cnt_q;
        case ({w_rsp_push, w_rsp_pop})
            2'b10:   w_rsp_cnt_d = r_rsp_cnt_q + c_RSP_CW'(1);
            2'b01:   w_rsp_cnt_d = r_rsp_cnt_q - c_RSP_CW'(1);
            default: w_rsp_cnt_d = r_rsp_cnt_q;
        endcase

        // Counter only lives across back-to-back stalled reads.
        w_to_cnt_d = '0;
        if (w_stall_rd && !w_to_reached) begin
            w_to_cnt_d = r_to_cnt_q + c_TO_W'(1);
        end

        w_wr_ack_d  = w_accept && s_cpuif_req_is_wr;
        w_wr_err_d  = w_accept && s_cpuif_req_is_wr && !(w_hit_cmd && w_biten_full);
        w_rd_ack_d  = w_accept && !s_cpuif_req_is_wr;
        w_rd_err_d  = w_accept && !s_cpuif_req_is_wr && !w_rsp_pop;
        w_rd_data_d = w_rsp_pop ? r_rsp_mem[r_rsp_rptr_q] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wptr_q] <= s_cpuif_wr_data;
        end
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wptr_q] <= resp_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cmd_wptr_q <= '0;
            r_cmd_rptr_q <= '0;
            r_cmd_cnt_q  <= '0;
            r_rsp_wptr_q <= '0;
            r_rsp_rptr_q <= '0;
            r_rsp_cnt_q  <= '0;
            r_to_cnt_q   <= '0;
            r_wr_ack_q   <= 1'b0;
            r_wr_err_q   <= 1'b0;
            r_rd_ack_q   <= 1'b0;
            r_rd_err_q   <= 1'b0;
            r_rd_data_q  <= '0;
        end else begin
            r_cmd_wptr_q <= w_cmd_wptr_d;
            r_cmd_rptr_q <= w_cmd_rptr_d;
            r_cmd_cnt_q  <= w_cmd_cnt_d;
            r_rsp_wptr_q <= w_rsp_wptr_d;
            r_rsp_rptr_q <= w_rsp_rptr_d;
            r_rsp_cnt_q  <= w_rsp_cnt_d;
            r_to_cnt_q   <= w_to_cnt_d;
            r_wr_ack_q   <= w_wr_ack_d;
            r_wr_err_q   <= w_wr_err_d;
            r_rd_ack_q   <= w_rd_ack_d;
            r_rd_err_q   <= w_rd_err_d;
            r_rd_data_q  <= w_rd_data_d;
        end
    end

`ifdef HCI_QUEUE_PORT_THLD_EN
    logic r_thld_q, w_thld_d;

    // Compared against the post-update count so the flag tracks resp_count_o.
    always_comb begin
        w_thld_d = (resp_thld_i != '0) && (w_rsp_cnt_d >= resp_thld_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_thld_q <= 1'b0;
        end else begin
            r_thld_q <= w_thld_d;
        end
    end

    assign resp_thld_o = r_thld_q;
`endif

    assign s_cpuif_req_stall_wr = w_stall_wr;
    assign s_cpuif_req_stall_rd = w_stall_rd;
    assign s_cpuif_wr_ack       = r_wr_ack_q;
    assign s_cpuif_wr_err       = r_wr_err_q;
    assign s_cpuif_rd_ack       = r_rd_ack_q;
    assign s_cpuif_rd_err       = r_rd_err_q;
    assign s_cpuif_rd_data      = r_rd_data_q;
    assign cmd_valid_o          = (r_cmd_cnt_q != '0);
    assign cmd_data_o           = cmd_valid_o ? r_cmd_mem[r_cmd_rptr_q] : '0;
    assign resp_ready_o         = !rst_i && (r_rsp_cnt_q != c_RSP_FULL);
    assign cmd_count_o          = r_cmd_cnt_q;
    assign resp_count_o         = r_rsp_cnt_q;

endmodule

`default_nettype wire
